squash_register_module: RTL and testbench
=========================================

# squash_register_module

Parametrised multi-port physical register file with per-register reader/writer locks and issue-ID age arbitration. It adds pipeline squash: every lock held or requested by an issue ID younger than a flush point is dropped in one cycle. It sits between the issue stage and the execution units of the out-of-order MIPS32 core. It is the successor to `register_module` and generalises data width, port count and ID width.

## Interface
- `NUM_PHY_REGS`, 64: number of physical registers; address width is `AW = $clog2(NUM_PHY_REGS)`.
- `TOTAL_PORTS`, 4: number of identical request ports.
- `ID_WIDTH`, 8: width of the issue ID; IDs wrap around.
- `DATA_WIDTH`, 32: width of one register.
- `clk  in  1  clock`.
- `rst_n  in  1  reset`. One clock; reset is asynchronous and active-low.
- `port_addr[TOTAL_PORTS]  in  AW  register address per port`.
- `port_req_read[TOTAL_PORTS]  in  1  shared read-lock request`.
- `port_req_write[TOTAL_PORTS]  in  1  exclusive write-lock request`. Read and write both high on one port is illegal.
- `port_issue_id[TOTAL_PORTS]  in  ID_WIDTH  age tag of the request`.
- `port_release[TOTAL_PORTS]  in  1  drop the lock at the next edge; a writer commits at that edge`.
- `port_wdata[TOTAL_PORTS]  in  DATA_WIDTH  write data`.
- `flush_valid  in  1  squash request`.
- `flush_id  in  ID_WIDTH  squash point; IDs younger than this are squashed`.
- `port_grant_out[TOTAL_PORTS]  out  1  lock granted (combinational)`.
- `port_rdata_out[TOTAL_PORTS]  out  DATA_WIDTH  register contents; 0 when not granted`.
- `port_squashed_out[TOTAL_PORTS]  out  1  registered pulse: this port's lock was dropped by a flush`.

## Operation
- **Age rule:** `older(a,b)` is true when `a-b`, taken mod 2^ID_WIDTH, has its MSB set. Equal IDs tie-break to the lower port index.
  - 250 is older than 10.
- **Lock state per register:** FREE, READING (holder bitmask), WRITING (single holder). A per-port `holding` flag is registered.
- **FREE:**
  - Find the oldest requester on the register.
  - If it is a writer, grant that writer alone.
  - If it is a reader, grant every reader older than the oldest pending writer.
- **READING:** holders keep their grant. A new reader joins only if no pending writer is older than it (writer anti-starvation).
- **WRITING:** only the holder is granted. Every other request waits.
- **Holding:** a granted port stays granted while its request stays high.
- **Release:** `port_release` with a grant drops the port's holding at the edge. A write holder also stores `port_wdata` at that edge. When the last holder leaves, the state becomes FREE.
- **Flush:** when `flush_valid` is high, every port with `older(flush_id, port_issue_id)` is squashed.
  - Its holding and grant are cleared at the edge and its write is not committed.
  - `port_squashed_out` pulses for 1 cycle for each port that was holding a lock.
  - Its grant is masked in the flush cycle itself.
  - A port whose ID equals `flush_id` is kept.
- **Simultaneous flush and release:** flush wins and no commit happens.
- **Reset:** storage becomes 0, all locks FREE, all holding flags 0. All outputs go to 0 immediately (asynchronous).
- **Address change while holding:** illegal. Assertion only; no defined behaviour.

## Timing
- Grant latency 0 cycles ("flash grant"): the grant is combinational from requests and registered lock state, and is valid within the same cycle.
- A write commits at the release edge. A reader granted in the following cycle sees the new data, with no bubble.
- Handover: the holder releases at edge N and the next waiter is granted in cycle N+1.
- `port_squashed_out` is asserted in the cycle after the flush edge.
- Storage contains no read-during-write bypass: the `rdata` of a register in WRITING belongs only to its holder, and the holder sees the old value.

## Configuration
- `SQUASH_REGFILE_ZERO_REG_EN`:
  - **Defined:** physical register 0 is hard-wired. Requests to it are always granted with no lock tracking. It reads 0 and its writes are discarded.
  - **Undefined:** register 0 behaves like any other register.

## Structure
- `regfile_pkg` holds:
  - the `lock_state_e` enum (FREE/READING/WRITING);
  - the `id_older()` function;
  - the default parameter constants.
- Sub-module `reg_lock_arbiter` is instantiated once per register. Its interface:
  - inputs: per-port match/read/write/ID/release/squash vectors;
  - outputs: the grant mask and the next lock state.
- The top level holds the storage array, the address decode and the grant OR-reduction.

## Test plan
- **Burst write:** ports 0-3 write R1-R4 with release → grant 1111. Reading R3 next cycle returns 3333_3333.
- **Writer priority:** P0 holds R70 as reader ID 40. P1 requests write ID 50 and P2 read ID 60 → grant 0001. After P0 releases → 0010.
- **Wrap-around:** P0 write ID 250 vs P1 write ID 10 on R50 → grant 0001.
- **Parallel read:** P0-P2 read R60 with IDs 10/11/12 → grant 0111.
- **Squash:**
  - Setup: P1 holds a write on R10 (ID 90, wdata CAFE_BABE) and P0 waits with a read (ID 100).
  - Action: `flush_id` = 95 with P1 releasing in the same cycle.
  - Required: P1 is not squashed and commits CAFE_BABE. P0 (ID 100) is squashed, so `port_squashed_out[0]`=0 because P0 held nothing, and its grant is masked.
  - Follow-up: re-running with `flush_id` = 80 squashes P1. `port_squashed_out[1]` pulses, R10 stays at its old value, and the lock goes FREE.
- **Reset mid-write:** assert `rst_n`=0 while P3 holds a write → grant 0000 immediately. After reset, R20 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, defaults and the wrap-around age compare for the
// squashable physical register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        FREE,
        READING,
        WRITING
    } lock_state_e;

    localparam int DEF_NUM_PHY_REGS = 64;
    localparam int DEF_TOTAL_PORTS  = 4;
    localparam int DEF_ID_WIDTH     = 8;
    localparam int DEF_DATA_WIDTH   = 32;

    // a is older than b when (a - b) mod 2^w has its top bit set.
    // Only the low w bits of the difference matter, so zero-extended
    // operands of any width up to 32 give the right answer.
    function automatic logic id_older(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [31:0] d;
        d = a - b;
        return d[w-1];
    endfunction

endpackage

// File: rtl/reg_lock_arbiter.sv
// Lock arbiter for one physical register: grants readers/writers by age.
// Ports: state (registered lock), per-port match/rd/wr/holding/rel/squash,
// per-port id, grant mask and next lock state.
module reg_lock_arbiter
    import regfile_pkg::*;
#(
    parameter int P   = DEF_TOTAL_PORTS,
    parameter int IDW = DEF_ID_WIDTH
) (
    input  lock_state_e          state,
    input  logic [P-1:0]         match,
    input  logic [P-1:0]         rd,
    input  logic [P-1:0]         wr,
    input  logic [P-1:0][IDW-1:0] id,
    input  logic [P-1:0]         holding,
    input  logic [P-1:0]         rel,
    input  logic [P-1:0]         squash,
    output logic [P-1:0]         grant,
    output lock_state_e          next_state
);

    logic [P-1:0]        req, hold, pend, pend_wr;
    logic [P-1:0]        reader_ok, oldest, nh;
    logic [P-1:0][P-1:0] bef;

    always_comb begin
        req     = match & (rd | wr) & ~squash;
        hold    = req & holding;
        pend    = req & ~holding;
        pend_wr = pend & wr;

        // bef[i][j]: port i ranks ahead of port j (age, then port index)
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                bef[i][j] = id_older(32'(id[i]), 32'(id[j]), IDW) ||
                            ((id[i] == id[j]) && (i < j));
            end
        end

        // a pending reader may go only if no pending writer ranks ahead
        for (int i = 0; i < P; i++) begin
            reader_ok[i] = pend[i] & rd[i];
            oldest[i]    = pend[i];
            for (int j = 0; j < P; j++) begin
                if (pend_wr[j] && bef[j][i]) reader_ok[i] = 1'b0;
                if (j != i && pend[j] && !bef[i][j]) oldest[i] = 1'b0;
            end
        end

        unique case (state)
            FREE:    grant = |(oldest & wr) ? (oldest & wr) : reader_ok;
            READING: grant = hold | reader_ok;
            WRITING: grant = hold;
            default: grant = '0;
        endcase

        nh = grant & ~rel;
        if (nh == '0)         next_state = FREE;
        else if (|(nh & wr))  next_state = WRITING;
        else                  next_state = READING;
    end

endmodule

// File: rtl/squash_register_module.sv
// Multi-port register file with per-register reader/writer locks, age
// arbitration and flush squash. Ports: per-port addr/req_read/req_write/
// issue_id/release/wdata, flush_valid/flush_id; outputs grant (comb),
// rdata (0 unless granted), squashed (registered pulse).
// Build option SQUASH_REGFILE_ZERO_REG_EN hard-wires register 0 to zero.
module squash_register_module
    import regfile_pkg::*;
#(
    parameter int NUM_PHY_REGS = DEF_NUM_PHY_REGS,
    parameter int TOTAL_PORTS  = DEF_TOTAL_PORTS,
    parameter int ID_WIDTH     = DEF_ID_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    localparam int AW          = $clog2(NUM_PHY_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AW-1:0]          port_addr [TOTAL_PORTS],
    input  logic [TOTAL_PORTS-1:0] port_req_read,
    input  logic [TOTAL_PORTS-1:0] port_req_write,
    input  logic [ID_WIDTH-1:0]    port_issue_id [TOTAL_PORTS],
    input  logic [TOTAL_PORTS-1:0] port_release,
    input  logic [DATA_WIDTH-1:0]  port_wdata [TOTAL_PORTS],
    input  logic                   flush_valid,
    input  logic [ID_WIDTH-1:0]    flush_id,
    output logic [TOTAL_PORTS-1:0] port_grant_out,
    output logic [DATA_WIDTH-1:0]  port_rdata_out [TOTAL_PORTS],
    output logic [TOTAL_PORTS-1:0] port_squashed_out
);

`ifdef SQUASH_REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_WIDTH-1:0]  mem [NUM_PHY_REGS];
    logic [TOTAL_PORTS-1:0] holding_q, squashed_q;
    logic [TOTAL_PORTS-1:0] req, squash, zr, grant;
    logic [TOTAL_PORTS-1:0] gnt_r [NUM_PHY_REGS];
    logic [TOTAL_PORTS-1:0][ID_WIDTH-1:0] id_pk;

    always_comb begin
        req = port_req_read | port_req_write;
        for (int p = 0; p < TOTAL_PORTS; p++) begin
            squash[p] = flush_valid &&
                id_older(32'(flush_id), 32'(port_issue_id[p]), ID_WIDTH);
            id_pk[p]  = port_issue_id[p];
            zr[p]     = ZERO_REG && (port_addr[p] == '0);
        end
    end

    for (genvar r = 0; r < NUM_PHY_REGS; r++) begin : g_reg
        logic [TOTAL_PORTS-1:0] match;

        always_comb begin
            for (int p = 0; p < TOTAL_PORTS; p++)
                match[p] = (port_addr[p] == AW'(r));
        end

        if (ZERO_REG && r == 0) begin : g_zero
            // no lock tracking: every live request goes straight through
            assign gnt_r[r] = match & req & ~squash;
        end else begin : g_lock
            lock_state_e state_q, state_d;

            reg_lock_arbiter #(
                .P   (TOTAL_PORTS),
                .IDW (ID_WIDTH)
            ) u_arb (
                .state      (state_q),
                .match      (match),
                .rd         (port_req_read),
                .wr         (port_req_write),
                .id         (id_pk),
                .holding    (holding_q),
                .rel        (port_release),
                .squash     (squash),
                .grant      (gnt_r[r]),
                .next_state (state_d)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) state_q <= FREE;
                else        state_q <= state_d;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int r = 0; r < NUM_PHY_REGS; r++)
            grant = grant | gnt_r[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holding_q  <= '0;
            squashed_q <= '0;
            for (int r = 0; r < NUM_PHY_REGS; r++)
                mem[r] <= '0;
        end else begin
            holding_q  <= grant & ~port_release & ~zr;
            squashed_q <= holding_q & squash & req;
            // squashed ports are never granted, so they never commit
            for (int p = 0; p < TOTAL_PORTS; p++) begin
                if (grant[p] && port_req_write[p] &&
                    port_release[p] && !zr[p])
                    mem[port_addr[p]] <= port_wdata[p];
            end
        end
    end

    // reset must silence grants at once, even with requests still high
    assign port_grant_out    = rst_n ? grant : '0;
    assign port_squashed_out = squashed_q;

    always_comb begin
        for (int p = 0; p < TOTAL_PORTS; p++) begin
            port_rdata_out[p] = (port_grant_out[p] && !zr[p]) ?
                                mem[port_addr[p]] : '0;
        end
    end

    for (genvar p = 0; p < TOTAL_PORTS; p++) begin : g_chk
        a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
            !(port_req_read[p] && port_req_write[p]));
        a_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (holding_q[p] && req[p]) |-> (port_addr[p] == $past(port_addr[p])));
    end

endmodule

// File: tb/tb_squash_register_module.sv
// Self-checking bench for squash_register_module: directed scenarios
// plus randomized traffic against a behavioural lock/age model.
module tb_squash_register_module;

    localparam int NP = 4;
    localparam int NR = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    addr [NP];
    logic [NP-1:0] rd, wr, rel;
    logic [7:0]    iid [NP];
    logic [31:0]   wd [NP];
    logic          fv;
    logic [7:0]    fid;
    logic [NP-1:0] grant, sq_out;
    logic [31:0]   rdata [NP];

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [31:0]   mem_m [NR];
    bit            held [NP];
    bit            held_wr [NP];
    int            held_addr [NP];
    logic [NP-1:0] sq_m;

    squash_register_module #(
        .NUM_PHY_REGS (NR),
        .TOTAL_PORTS  (NP),
        .ID_WIDTH     (8),
        .DATA_WIDTH   (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .port_addr         (addr),
        .port_req_read     (rd),
        .port_req_write    (wr),
        .port_issue_id     (iid),
        .port_release      (rel),
        .port_wdata        (wd),
        .flush_valid       (fv),
        .flush_id          (fid),
        .port_grant_out    (grant),
        .port_rdata_out    (rdata),
        .port_squashed_out (sq_out)
    );

    always #5 clk = ~clk;

    function automatic bit older_m(int a, int b);
        return ((((a - b) % 256) + 256) % 256) >= 128;
    endfunction

    function automatic bit first_m(int p, int q);
        return older_m(int'(iid[p]), int'(iid[q])) ||
               (iid[p] == iid[q] && p < q);
    endfunction

    function automatic bit squashed_m(int p);
        return fv && older_m(int'(fid), int'(iid[p]));
    endfunction

    function automatic logic [NP-1:0] exp_grant();
        logic [NP-1:0] g;
        bit act [NP];
        int r, mode, best;
        bit ok;
        g = '0;
        for (int p = 0; p < NP; p++)
            act[p] = (rd[p] || wr[p]) && !squashed_m(p);
        for (int p = 0; p < NP; p++) begin
            if (!act[p]) continue;
            if (held[p]) begin
                g[p] = 1'b1;
                continue;
            end
            r = int'(addr[p]);
            mode = 0;
            for (int q = 0; q < NP; q++)
                if (held[q] && held_addr[q] == r)
                    mode = held_wr[q] ? 2 : ((mode == 2) ? 2 : 1);
            ok = rd[p];
            for (int q = 0; q < NP; q++)
                if (act[q] && !held[q] && wr[q] &&
                    int'(addr[q]) == r && first_m(q, p))
                    ok = 1'b0;
            if (mode == 1) begin
                g[p] = ok;
            end else if (mode == 0) begin
                best = -1;
                for (int q = 0; q < NP; q++)
                    if (act[q] && !held[q] && int'(addr[q]) == r &&
                        (best < 0 || first_m(q, best)))
                        best = q;
                g[p] = wr[best] ? (best == p) : ok;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) mem_m[r] = '0;
        for (int p = 0; p < NP; p++) begin
            held[p] = 1'b0;
            held_wr[p] = 1'b0;
            held_addr[p] = 0;
        end
        sq_m = '0;
    endtask

    task automatic idle();
        rd = '0; wr = '0; rel = '0; fv = 1'b0; fid = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p] = '0; iid[p] = '0; wd[p] = '0;
        end
    endtask

    task automatic drive(int p, int a, bit r, bit w, int id, bit rl, logic [31:0] d);
        addr[p] = 7'(a); rd[p] = r; wr[p] = w;
        iid[p] = 8'(id); rel[p] = rl; wd[p] = d;
    endtask

    // advance one clock, updating the model with what the edge should do
    task automatic tick();
        logic [NP-1:0] g;
        g = exp_grant();
        for (int p = 0; p < NP; p++)
            sq_m[p] = held[p] && squashed_m(p) && (rd[p] || wr[p]);
        for (int p = 0; p < NP; p++) begin
            if (g[p] && wr[p] && rel[p]) mem_m[addr[p]] = wd[p];
            held[p] = g[p] && !rel[p];
            held_wr[p] = wr[p];
            held_addr[p] = int'(addr[p]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (grant !== 4'b0000) begin
            bad++; $display("FAIL reset_grant got=%b want=0000", grant);
        end
        total++;
        if (sq_out !== 4'b0000) begin
            bad++; $display("FAIL reset_squashed got=%b want=0000", sq_out);
        end
        rst_n = 1'b1;
        drive(0, 5, 1, 0, 1, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin
            bad++; $display("FAIL reset_read_grant got=%b want=0001", grant);
        end
        total++;
        if (rdata[0] !== 32'h0) begin
            bad++; $display("FAIL reset_read_data got=%h want=0", rdata[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_burst_write();
        for (int p = 0; p < NP; p++)
            drive(p, p + 1, 0, 1, p + 3, 1, 32'h1111_1111 * (p + 1));
        @(negedge clk);
        total++;
        if (grant !== 4'b1111) begin
            bad++; $display("FAIL burst_grant got=%b want=1111", grant);
        end
        tick();
        idle();
        drive(0, 3, 1, 0, 9, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || rdata[0] !== 32'h3333_3333) begin
            bad++;
            $display("FAIL burst_readback got=%b/%h want=0001/33333333", grant, rdata[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_writer_priority();
        drive(0, 70, 1, 0, 40, 0, 0);
        tick();
        drive(1, 70, 0, 1, 50, 0, 32'h5555_0000);
        drive(2, 70, 1, 0, 60, 0, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin
            bad++; $display("FAIL prio_held got=%b want=0001", grant);
        end
        tick();
        rel[0] = 1'b1;
        tick();
        rd[0] = 1'b0; rel[0] = 1'b0; rel[1] = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin
            bad++; $display("FAIL prio_handover got=%b want=0010", grant);
        end
        tick();
        wr[1] = 1'b0; rel[1] = 1'b0; rel[2] = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0100 || rdata[2] !== 32'h5555_0000) begin
            bad++;
            $display("FAIL prio_reader_after got=%b/%h want=0100/55550000", grant, rdata[2]);
        end
        tick();
        idle();
    endtask

    task automatic test_wrap();
        drive(0, 50, 0, 1, 250, 1, 32'hAAAA_0001);
        drive(1, 50, 0, 1, 10, 1, 32'hBBBB_0002);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin
            bad++; $display("FAIL wrap_grant got=%b want=0001", grant);
        end
        tick();
        idle();
    endtask

    task automatic test_parallel_read();
        for (int p = 0; p < 3; p++) drive(p, 60, 1, 0, 10 + p, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0111) begin
            bad++; $display("FAIL par_read got=%b want=0111", grant);
        end
        tick();
        idle();
    endtask

    task automatic test_squash();
        drive(1, 10, 0, 1, 90, 0, 32'hCAFE_BABE);
        drive(0, 10, 1, 0, 100, 0, 0);
        tick();
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin
            bad++; $display("FAIL squash_setup got=%b want=0010", grant);
        end
        fv = 1'b1; fid = 8'd95; rel[1] = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin
            bad++; $display("FAIL squash_keep got=%b want=0010", grant);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (sq_out !== 4'b0000) begin
            bad++; $display("FAIL squash_no_pulse got=%b want=0000", sq_out);
        end
        drive(0, 10, 1, 0, 100, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || rdata[0] !== 32'hCAFE_BABE) begin
            bad++;
            $display("FAIL squash_commit got=%b/%h want=0001/cafebabe", grant, rdata[0]);
        end
        tick();
        idle();
        drive(1, 10, 0, 1, 90, 0, 32'h1234_5678);
        tick();
        fv = 1'b1; fid = 8'd80; rel[1] = 1'b1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000) begin
            bad++; $display("FAIL squash_mask got=%b want=0000", grant);
        end
        tick();
        idle();
        @(negedge clk);
        total++;
        if (sq_out !== 4'b0010) begin
            bad++; $display("FAIL squash_pulse got=%b want=0010", sq_out);
        end
        drive(0, 10, 1, 0, 120, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b0001 || rdata[0] !== 32'hCAFE_BABE) begin
            bad++;
            $display("FAIL squash_no_commit got=%b/%h want=0001/cafebabe", grant, rdata[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [NP-1:0] eg;
        int k;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (held[p]) begin
                    rel[p] = ($urandom_range(0, 2) == 0);
                    wd[p] = $urandom();
                end else begin
                    k = $urandom_range(0, 3);
                    rd[p] = (k == 1 || k == 3);
                    wr[p] = (k == 2);
                    addr[p] = 7'(40 + $urandom_range(0, 2));
                    iid[p] = 8'(252 + $urandom_range(0, 9));
                    rel[p] = ($urandom_range(0, 3) == 0);
                    wd[p] = $urandom();
                end
            end
            fv = ($urandom_range(0, 9) == 0);
            fid = 8'(252 + $urandom_range(0, 9));
            eg = exp_grant();
            @(negedge clk);
            total++;
            if (grant !== eg) begin
                bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, grant, eg);
            end
            for (int p = 0; p < NP; p++) begin
                total++;
                if (rdata[p] !== (eg[p] ? mem_m[addr[p]] : 32'h0)) begin
                    bad++;
                    $display("FAIL rand_rdata c=%0d p=%0d got=%h want=%h", c, p,
                             rdata[p], eg[p] ? mem_m[addr[p]] : 32'h0);
                end
            end
            total++;
            if (sq_out !== sq_m) begin
                bad++; $display("FAIL rand_squashed c=%0d got=%b want=%b", c, sq_out, sq_m);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_write();
        idle();
        drive(3, 20, 0, 1, 7, 1, 32'h1111_1111);
        tick();
        drive(3, 20, 0, 1, 7, 0, 32'hDEAD_BEEF);
        @(negedge clk);
        total++;
        if (grant !== 4'b1000) begin
            bad++; $display("FAIL midrst_hold got=%b want=1000", grant);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (grant !== 4'b0000 || rdata[3] !== 32'h0) begin
            bad++;
            $display("FAIL midrst_grant got=%b/%h want=0000/0", grant, rdata[3]);
        end
        model_reset();
        @(posedge clk);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3, 20, 1, 0, 8, 1, 0);
        @(negedge clk);
        total++;
        if (grant !== 4'b1000 || rdata[3] !== 32'h0) begin
            bad++;
            $display("FAIL midrst_readback got=%b/%h want=1000/0", grant, rdata[3]);
        end
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_burst_write();
        test_writer_priority();
        test_wrap();
        test_parallel_read();
        test_squash();
        test_random();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
